// File: rtl/config_fabric_if.sv
// Config-bus bundle for config_fabric: the upstream Avalon-MM slave port
// (avs_config_*) and the flattened per-slave downstream ports (m_*).
// The fabric connects through the "slave" modport; the HPS side and the
// downstream slaves together form the "master" view.
//
// Handshake: a request (read or write) is held stable by the requester
// while avs_config_waitrequest / m_waitrequest[i] is 1 and is taken on the
// first rising edge where it is 0; read data is qualified only by
// *_readdatavalid and is returned in the order the reads were accepted.
interface config_fabric_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32
);
    // upstream (HPS-facing) port
    logic [ADDR_W-1:0]            avs_config_address;
    logic                         avs_config_write;
    logic [DATA_W-1:0]            avs_config_writedata;
    logic                         avs_config_read;
    logic                         avs_config_waitrequest;
    logic [DATA_W-1:0]            avs_config_readdata;
    logic                         avs_config_readdatavalid;

    // downstream ports, slice i belongs to slave i
    logic [NUM_SLAVES*ADDR_W-1:0] m_address;
    logic [NUM_SLAVES-1:0]        m_write;
    logic [NUM_SLAVES*DATA_W-1:0] m_writedata;
    logic [NUM_SLAVES-1:0]        m_read;
    logic [NUM_SLAVES-1:0]        m_waitrequest;
    logic [NUM_SLAVES*DATA_W-1:0] m_readdata;
    logic [NUM_SLAVES-1:0]        m_readdatavalid;

    // router side
    modport slave (
        input  avs_config_address, avs_config_write, avs_config_writedata,
        input  avs_config_read,
        output avs_config_waitrequest, avs_config_readdata,
        output avs_config_readdatavalid,
        output m_address, m_write, m_writedata, m_read,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    // environment side: HPS requester plus downstream responders
    modport master (
        output avs_config_address, avs_config_write, avs_config_writedata,
        output avs_config_read,
        input  avs_config_waitrequest, avs_config_readdata,
        input  avs_config_readdatavalid,
        input  m_address, m_write, m_writedata, m_read,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/config_fabric.sv
// config_fabric: routes the single HPS config port to NUM_SLAVES config
// slaves. The top SEL_W address bits pick the slave; requests are forwarded
// combinationally, read responses come back registered and strictly in
// order. Reads are only allowed to pile up against one slave at a time, so
// ordering never needs a reorder buffer. Unmapped reads and reads whose
// slave stays silent for TIMEOUT cycles return ERR_WORD; a slave that later
// answers a timed-out read has that answer swallowed through its stale count.
//
// Parameter constraints: MAX_PENDING is a power of 2 and at least 2,
// TIMEOUT >= 1, SEL_W wide enough to encode NUM_SLAVES-1. The interface
// instance must be built with the same NUM_SLAVES/ADDR_W/DATA_W.
module config_fabric #(
    parameter int               NUM_SLAVES  = 4,
    parameter int               ADDR_W      = 16,
    parameter int               DATA_W      = 32,
    parameter int               SEL_W       = 4,
    parameter int               MAX_PENDING = 4,
    parameter int               TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] ERR_WORD   = DATA_W'(32'hDEADBEEF)
) (
    input  logic           clk,
    input  logic           reset,
    config_fabric_if.slave bus
);

    // entry index width: 0..NUM_SLAVES-1 are real slaves, NUM_SLAVES = unmapped
    localparam int IDX_W  = $clog2(NUM_SLAVES + 1);
    localparam int PTR_W  = $clog2(MAX_PENDING);
    localparam int CNT_W  = $clog2(MAX_PENDING + 1);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int STL_W  = $clog2(MAX_PENDING + 1);
    localparam int SEL_W1 = SEL_W + 1;

    localparam logic [IDX_W-1:0]  ERR_IDX   = IDX_W'(NUM_SLAVES);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_PENDING);
    localparam logic [TMR_W-1:0]  TMO_VAL   = TMR_W'(TIMEOUT);
    localparam logic [STL_W-1:0]  STALE_MAX = STL_W'(MAX_PENDING);
    localparam logic [SEL_W:0]    NUM_SEL   = SEL_W1'(NUM_SLAVES);

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  fifo_q [MAX_PENDING];
    logic [IDX_W-1:0]  fifo_d [MAX_PENDING];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;   // index of most recent push
    logic [TMR_W-1:0]  timer_q, timer_d;         // cycles the head has waited
    logic [STL_W-1:0]  stale_q [NUM_SLAVES];     // late answers still owed per slave
    logic [STL_W-1:0]  stale_d [NUM_SLAVES];
    logic              readdatavalid_q, readdatavalid_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;

    // ------------------------------------------------------------------
    // request-side decode
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]      sel;
    logic                  mapped;
    logic [IDX_W-1:0]      req_idx;
    logic                  rblk;
    logic                  sel_wait;
    logic                  waitreq;
    logic                  accept;
    logic [NUM_SLAVES-1:0] m_read_c;
    logic [NUM_SLAVES-1:0] m_write_c;

    // head-of-queue view
    logic [IDX_W-1:0]  head_sel;
    logic              head_rdv;
    logic              head_fresh;
    logic [DATA_W-1:0] head_data;

    // response-side control
    logic has_entries;
    logic pop;
    logic stale_inc;

    assign sel     = bus.avs_config_address[ADDR_W-1 -: SEL_W];
    assign mapped  = ({1'b0, sel} < NUM_SEL);
    assign req_idx = mapped ? IDX_W'(sel) : ERR_IDX;

    // Decode the request, forward strobes to the selected slave and decide the upstream stall.
    always_comb begin
        // A full queue blocks even if it pops this cycle; a different target waits for drain.
        rblk      = (count_q == FULL_CNT) ||
                    ((count_q != '0) && (req_idx != last_idx_q));
        sel_wait  = 1'b0;
        m_read_c  = '0;
        m_write_c = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (mapped && (sel == SEL_W'(i))) begin
                m_read_c[i]  = bus.avs_config_read & ~rblk;
                m_write_c[i] = bus.avs_config_write;
                sel_wait     = bus.m_waitrequest[i];
            end
        end
        waitreq = 1'b0;
        if (bus.avs_config_read) begin
            waitreq = mapped ? (sel_wait | rblk) : rblk;
        end else if (bus.avs_config_write) begin
            // unmapped writes complete at once and are simply dropped
            waitreq = mapped & sel_wait;
        end
        accept = bus.avs_config_read & ~waitreq;
    end

    // Look up the oldest outstanding read and what its slave is presenting.
    always_comb begin
        head_sel   = fifo_q[rd_ptr_q];
        head_rdv   = 1'b0;
        head_fresh = 1'b0;
        head_data  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (head_sel == IDX_W'(i)) begin
                head_rdv   = bus.m_readdatavalid[i];
                head_fresh = (stale_q[i] == '0);
                head_data  = bus.m_readdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pick the response, advance the tracking queue, timer and stale counters.
    always_comb begin
        fifo_d          = fifo_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        last_idx_d      = last_idx_q;
        stale_d         = stale_q;
        readdata_d      = readdata_q;
        readdatavalid_d = 1'b0;
        pop             = 1'b0;
        stale_inc       = 1'b0;
        has_entries     = (count_q != '0);

        if (has_entries && (head_sel == ERR_IDX)) begin
            pop        = 1'b1;
            readdata_d = ERR_WORD;
        end else if (has_entries && head_rdv && head_fresh) begin
            pop        = 1'b1;
            readdata_d = head_data;
        end else if (has_entries && (timer_q == TMO_VAL)) begin
            // give up on the head; its slave now owes one answer we must discard
            pop        = 1'b1;
            readdata_d = ERR_WORD;
            stale_inc  = 1'b1;
        end
        readdatavalid_d = pop;

        // A late answer and a new timeout on the same slave cancel out.
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (stale_inc && (head_sel == IDX_W'(i)) &&
                !(bus.m_readdatavalid[i] && (stale_q[i] != '0))) begin
                if (stale_q[i] != STALE_MAX) begin
                    stale_d[i] = stale_q[i] + 1'b1;
                end
            end else if (!(stale_inc && (head_sel == IDX_W'(i))) &&
                         bus.m_readdatavalid[i] && (stale_q[i] != '0)) begin
                stale_d[i] = stale_q[i] - 1'b1;
            end
        end

        if (!has_entries || pop) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (accept) begin
            fifo_d[wr_ptr_q] = req_idx;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            last_idx_d       = req_idx;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers with synchronous active-low reset that flushes everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MAX_PENDING; i++) begin
                fifo_q[i] <= '0;
            end
            for (int i = 0; i < NUM_SLAVES; i++) begin
                stale_q[i] <= '0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            last_idx_q      <= '0;
            timer_q         <= '0;
            readdatavalid_q <= 1'b0;
            readdata_q      <= '0;
        end else begin
            fifo_q          <= fifo_d;
            stale_q         <= stale_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            last_idx_q      <= last_idx_d;
            timer_q         <= timer_d;
            readdatavalid_q <= readdatavalid_d;
            readdata_q      <= readdata_d;
        end
    end

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign bus.avs_config_waitrequest   = waitreq;
    assign bus.avs_config_readdata      = readdata_q;
    assign bus.avs_config_readdatavalid = readdatavalid_q;
    assign bus.m_address                = {NUM_SLAVES{bus.avs_config_address}};
    assign bus.m_writedata              = {NUM_SLAVES{bus.avs_config_writedata}};
    assign bus.m_read                   = m_read_c;
    assign bus.m_write                  = m_write_c;

endmodule

// File: doc/config_fabric.md
# config_fabric

Parametrised Avalon-MM config-bus router between the single HPS-facing config slave port and `NUM_SLAVES` downstream config slaves (memory access, controller, later units). It replaces ad-hoc wired-OR read-data sharing with address decode, per-slave waitrequest forwarding, and in-order tracking of pipelined reads. It adds a read timeout with error response and an unmapped-address error response. It sits in the top-level wrapper between `avs_config_*` and the sub-block config ports.

## Interface

**Parameters**

- `NUM_SLAVES`, default 4: number of downstream slaves.
- `ADDR_W`, default 16: config address width.
- `DATA_W`, default 32: config data width.
- `SEL_W`, default 4: top address bits used as slave index; index is `address[ADDR_W-1 -: SEL_W]`.
- `MAX_PENDING`, default 4: maximum outstanding reads (power of 2).
- `TIMEOUT`, default 255: cycles the head read may wait before an error response.
- `ERR_WORD`, default 32'hDEADBEEF: data returned on timeout or unmapped read.

**Ports**

- Clock and reset are decided as follows: one clock; reset is synchronous and active-low.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `avs_config_address` in ADDR_W: upstream address.
- `avs_config_write` in 1: upstream write.
- `avs_config_writedata` in DATA_W: upstream write data.
- `avs_config_read` in 1: upstream read.
- `avs_config_waitrequest` out 1: upstream stall.
- `avs_config_readdata` out DATA_W: upstream read data.
- `avs_config_readdatavalid` out 1: upstream read data valid.
- `m_address` out NUM_SLAVES*ADDR_W: per-slave address; the full address is broadcast to every slice.
- `m_write` out NUM_SLAVES: per-slave write strobe.
- `m_writedata` out NUM_SLAVES*DATA_W: per-slave write data; broadcast.
- `m_read` out NUM_SLAVES: per-slave read strobe.
- `m_waitrequest` in NUM_SLAVES: per-slave stall.
- `m_readdata` in NUM_SLAVES*DATA_W: per-slave read data; slice i belongs to slave i.
- `m_readdatavalid` in NUM_SLAVES: per-slave read data valid.

## Operation

**Decode**

- `sel` is the index field of the address.
- `mapped` is `sel < NUM_SLAVES`.

**Read tracking FIFO**

- Depth MAX_PENDING.
- Each entry holds a slave index, or the pseudo-index NUM_SLAVES for unmapped reads.
- `count` ranges 0..MAX_PENDING.
- `head_sel` is the index of the oldest entry.

**Read block condition `rblk`**, asserted when any of the following holds:

- `count == MAX_PENDING`; a pop in the same cycle is ignored.
- `count != 0` and the entry's index differs from the index of the most recently pushed entry. Reads to a different slave wait for drain, which guarantees in-order return.

**Forwarding (combinational)**

- `m_read[sel]` is `avs_config_read & mapped & ~rblk`.
- `m_write[sel]` is `avs_config_write & mapped`.
- All other strobes are 0.
- `avs_config_waitrequest` is defined per request type:
  - Mapped read: `m_waitrequest[sel] | rblk`.
  - Unmapped read: `rblk`.
  - Mapped write: `m_waitrequest[sel]`.
  - Unmapped write: 0, and the write is discarded.
  - Idle: 0.
- Writes are never blocked by pending reads.

**Read acceptance**

- A read is accepted when `avs_config_read & ~avs_config_waitrequest`.
- On acceptance, push `mapped ? sel : NUM_SLAVES`.

**Response selection (registered)**

- Case 1: `head_sel == NUM_SLAVES`, count > 0. Return ERR_WORD and pop.
- Case 2: `m_readdatavalid[head_sel]`, count > 0, and the slave's stale counter is 0. Return `m_readdata[head_sel]` and pop.
- Case 3: timer reaches TIMEOUT. Return ERR_WORD, pop, and increment `stale[head_sel]`, saturating at MAX_PENDING.

**Timer**

- Counts while count > 0 and no pop.
- Clears on every pop and whenever count == 0.

**Stale handling**

- `m_readdatavalid[i]` with `stale[i] > 0` is dropped and decrements `stale[i]`.
- The drop takes priority over case 2 in the same cycle.

**Other rules**

- Any `m_readdatavalid[i]` with i ≠ head_sel and `stale[i] == 0` is ignored.
- Simultaneous push and pop: count is unchanged, and both pointers advance.

## Timing

**Reset values** (while reset is low at a clock edge):

- `avs_config_readdatavalid` 0.
- `avs_config_readdata` 0.
- count 0, pointers 0, timer 0, all stale 0.
- Combinational outputs follow inputs with an empty FIFO.

**Latency**

- Request path has 0 cycles of latency (combinational).
- Response appears exactly 1 cycle after the slave's `m_readdatavalid`.
- Unmapped read response appears 1 cycle after it becomes head.
- Timeout response is registered on the edge where the timer equals TIMEOUT. That is TIMEOUT+1 cycles after the entry becomes head with no response.

**Throughput and ordering**

- At most one response per cycle.
- Back-to-back reads to the same slave sustain 1 per cycle up to MAX_PENDING.

**Reset mid-operation**

- Flushes the FIFO and all stale counters.
- Late slave responses after reset are ignored, because count is 0.

## Test plan

- **Reset outputs:** hold reset low 3 cycles -> `avs_config_readdatavalid`=0, readdata=0, and `avs_config_waitrequest`=0 with no request.
- **Same-slave pipelined reads:** 4 back-to-back reads to slave 1 (addr 0x1000..0x1003), slave returns 0xA0..0xA3 at 2-cycle latency -> upstream sees 0xA0..0xA3 in order, each 1 cycle after the slave valid. A 5th read stalls until the first pop.
- **Cross-slave ordering:** read slave 0 (pending), then read slave 2 -> `avs_config_waitrequest`=1 and `m_read[2]`=0 until slave 0's response pops. Then `m_read[2]` pulses once.
- **Unmapped access:** with NUM_SLAVES=4, read at 0x5000 -> ERR_WORD 0xDEADBEEF with no slave strobe. Write to 0x5000 -> waitrequest 0 and all `m_write`=0.
- **Timeout and stale drop:** with TIMEOUT=8, read slave 3 and withhold response -> ERR_WORD at cycle 9 after acceptance. A late `m_readdatavalid[3]` with 0x55 is dropped. A following read to slave 3 returning 0x66 delivers 0x66.
- **Reset mid-operation:** 2 reads pending on slave 0, then reset pulse, then slave 0 returns data -> no upstream readdatavalid, and count=0.
